// File: rtl/gauss_noise_scaler.sv
// -----------------------------------------------------------------------------
// gauss_noise_scaler
//
// Purpose:
//   Consumes one signed fixed-point N(0,1) sample per cycle from the gaussian
//   RNG and multiplies it by a programmable amplitude sigma. The product is
//   rounded half up, saturated and buffered in a first-word-fall-through FIFO.
//   A valid/ready handshake feeds the LBM fluctuating-collision stage.
//   The FIFO lets the free-running generator keep going while the collision
//   pipeline stalls. Samples that arrive while the FIFO is full are dropped
//   and counted.
//
// Optional feature:
//   NOISE_STATS_EN - when defined, a running signed sum and a count of written
//                    samples are built. When undefined, o_stat_sum and
//                    o_stat_count are tied to 0.
//
// Ports:
//   i_clk           clock, rising edge
//   i_rst           asynchronous reset, active high
//   i_enable        intake enable; accept = i_enable & i_sample_valid
//   i_sample_in     signed gaussian sample, Q(DW-FB).FB
//   i_sample_valid  i_sample_in valid this cycle
//   i_sigma_in      new amplitude, signed Q(DW-FB).FB, non-negative by use
//   i_sigma_load    capture i_sigma_in
//   o_noise_out     FIFO head (scaled sample); 0 while empty
//   o_noise_valid   FIFO non-empty
//   i_noise_ready   consumer pop; pop = o_noise_valid & i_noise_ready
//   o_fill_level    entries held (0..DEPTH)
//   o_drop_count    samples lost to a full FIFO, saturating
//   o_stat_sum      signed sum of written samples (NOISE_STATS_EN)
//   o_stat_count    count of written samples (NOISE_STATS_EN)
// -----------------------------------------------------------------------------
module gauss_noise_scaler #(
  parameter int                      DATA_WIDTH      = 32,
  parameter int                      FRACTIONAL_BITS = 24,
  parameter int                      DEPTH           = 16,
  parameter logic [DATA_WIDTH-1:0]   SIGMA_RESET     = 32'h0100_0000
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_enable,
  input  logic [DATA_WIDTH-1:0]         i_sample_in,
  input  logic                          i_sample_valid,
  input  logic [DATA_WIDTH-1:0]         i_sigma_in,
  input  logic                          i_sigma_load,
  output logic [DATA_WIDTH-1:0]         o_noise_out,
  output logic                          o_noise_valid,
  input  logic                          i_noise_ready,
  output logic [$clog2(DEPTH):0]        o_fill_level,
  output logic [15:0]                   o_drop_count,
  output logic [47:0]                   o_stat_sum,
  output logic [31:0]                   o_stat_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int SW = 48;

  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

  // Rounding bias 2^(FB-1) and saturation limits, all one bit wider than
  // the product so the bias add can never wrap.
  localparam logic signed [PW:0] RND_BIAS =
    {{(PW-FRACTIONAL_BITS+1){1'b0}}, 1'b1, {(FRACTIONAL_BITS-1){1'b0}}};
  localparam logic signed [PW:0] SAT_MAX =
    {{(PW-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PW:0] SAT_MIN =
    {{(PW-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  // Round half up (toward +inf on ties), drop FB fractional bits, clamp to
  // the output range.
  function automatic logic [DATA_WIDTH-1:0] round_sat(input logic signed [PW-1:0] prod);
    logic signed [PW:0] ext;
    logic signed [PW:0] rnd;
    logic signed [PW:0] shf;
    ext = {prod[PW-1], prod};
    rnd = ext + RND_BIAS;
    shf = rnd >>> FRACTIONAL_BITS;
    if (shf > SAT_MAX) begin
      round_sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (shf < SAT_MIN) begin
      round_sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      round_sat = shf[DATA_WIDTH-1:0];
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]        r_sigma;
  logic signed [PW-1:0]         r_prod;
  logic                         r_s1_valid;
  logic [DATA_WIDTH-1:0]        r_mem [DEPTH];
  logic [AW-1:0]                r_wr_ptr;
  logic [AW-1:0]                r_rd_ptr;
  logic [CW-1:0]                r_count;
  logic [DATA_WIDTH-1:0]        r_noise_out;
  logic                         r_noise_valid;
  logic [15:0]                  r_drop_count;

  // ---------------------------------------------------------------------------
  // Combinational nets
  // ---------------------------------------------------------------------------
  logic                         w_accept;
  logic signed [PW-1:0]         w_sample_ext;
  logic signed [PW-1:0]         w_sigma_ext;
  logic [DATA_WIDTH-1:0]        w_wdata;
  logic                         w_pop;
  logic                         w_full;
  logic                         w_push;
  logic                         w_drop;
  logic [CW-1:0]                w_count_after_pop;
  logic [CW-1:0]                w_count_nxt;
  logic [AW-1:0]                w_rd_nxt;
  logic [DATA_WIDTH-1:0]        w_head_nxt;

  assign w_accept     = i_enable & i_sample_valid;
  assign w_sample_ext = {{DATA_WIDTH{i_sample_in[DATA_WIDTH-1]}}, i_sample_in};
  assign w_sigma_ext  = {{DATA_WIDTH{r_sigma[DATA_WIDTH-1]}}, r_sigma};
  assign w_wdata      = round_sat(r_prod);

  // A push into a full FIFO is still legal when the head leaves on the same edge.
  assign w_pop  = r_noise_valid & i_noise_ready;
  assign w_full = (r_count == FULL_LVL);
  assign w_push = r_s1_valid & (~w_full | w_pop);
  assign w_drop = r_s1_valid & ~w_push;

  assign w_count_after_pop = r_count - {{AW{1'b0}}, w_pop};
  assign w_rd_nxt          = w_pop ? (r_rd_ptr + {{(AW-1){1'b0}}, 1'b1}) : r_rd_ptr;

  // Next occupancy from the push/pop pair.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + {{AW{1'b0}}, 1'b1};
      2'b01:   w_count_nxt = r_count - {{AW{1'b0}}, 1'b1};
      default: w_count_nxt = r_count;
    endcase
  end

  // Next head value, so that o_noise_out can be a plain register. The new
  // head is the word being written only when nothing older survives the pop.
  always_comb begin
    w_head_nxt = {DATA_WIDTH{1'b0}};
    if (w_count_nxt == {CW{1'b0}}) begin
      w_head_nxt = {DATA_WIDTH{1'b0}};
    end else if (w_push && (w_count_after_pop == {CW{1'b0}})) begin
      w_head_nxt = w_wdata;
    end else begin
      w_head_nxt = r_mem[w_rd_nxt];
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // Amplitude register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sigma <= SIGMA_RESET;
    end else if (i_sigma_load) begin
      r_sigma <= i_sigma_in;
    end
  end

  // Multiply stage; sigma as it stood before this edge is used.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prod     <= {PW{1'b0}};
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_prod <= w_sample_ext * w_sigma_ext;
      end
    end
  end

  // FIFO storage and pointers; pointers wrap naturally since DEPTH is 2^AW.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {DATA_WIDTH{1'b0}};
      end
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_wdata;
        r_wr_ptr        <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_count_nxt;
    end
  end

  // Registered head and valid flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_noise_out   <= {DATA_WIDTH{1'b0}};
      r_noise_valid <= 1'b0;
    end else begin
      r_noise_out   <= w_head_nxt;
      r_noise_valid <= (w_count_nxt != {CW{1'b0}});
    end
  end

  // Saturating count of samples lost to a full FIFO.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_drop_count <= 16'h0000;
    end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
      r_drop_count <= r_drop_count + 16'h0001;
    end
  end

  assign o_noise_out   = r_noise_out;
  assign o_noise_valid = r_noise_valid;
  assign o_fill_level  = r_count;
  assign o_drop_count  = r_drop_count;

`ifdef NOISE_STATS_EN
  logic [SW-1:0] r_stat_sum;
  logic [31:0]   r_stat_count;

  // Running statistics over written samples only; the sum wraps and the
  // count saturates.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stat_sum   <= {SW{1'b0}};
      r_stat_count <= 32'h0000_0000;
    end else if (w_push) begin
      r_stat_sum <= r_stat_sum + {{(SW-DATA_WIDTH){w_wdata[DATA_WIDTH-1]}}, w_wdata};
      if (r_stat_count != 32'hFFFF_FFFF) begin
        r_stat_count <= r_stat_count + 32'h0000_0001;
      end
    end
  end

  assign o_stat_sum   = r_stat_sum;
  assign o_stat_count = r_stat_count;
`else
  assign o_stat_sum   = 48'h0000_0000_0000;
  assign o_stat_count = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_gauss_noise_scaler.sv
// -----------------------------------------------------------------------------
// tb_gauss_noise_scaler
//
// Self-checking bench for gauss_noise_scaler. A cycle model holds the
// pending multiply result, the FIFO contents as a queue, the drop count
// and sigma. Expected words are pushed into the queue when stimulus is
// driven, and popped when the model sees a consumer pop. Every cycle is
// compared against the DUT. Scaling vectors come from a local table, and
// hand-written sequences cover the FIFO corner cases and reset.
// -----------------------------------------------------------------------------
module tb_gauss_noise_scaler;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [31:0] sample_in;
  logic        sample_valid;
  logic [31:0] sigma_in;
  logic        sigma_load;
  logic [31:0] noise_out;
  logic        noise_valid;
  logic        noise_ready;
  logic [4:0]  fill_level;
  logic [15:0] drop_count;
  logic [47:0] stat_sum;
  logic [31:0] stat_count;

  int n_chk;
  int n_err;

  // model state
  logic [31:0] m_q[$];
  logic        m_s1v;
  logic [31:0] m_s1d;
  logic [15:0] m_drop;
  logic [31:0] m_sigma;

  typedef struct {
    string       name;
    logic [31:0] sigma;
    logic [31:0] sample;
    logic [31:0] expv;
  } vec_t;
  vec_t vecs[8];

  gauss_noise_scaler dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_enable       (enable),
    .i_sample_in    (sample_in),
    .i_sample_valid (sample_valid),
    .i_sigma_in     (sigma_in),
    .i_sigma_load   (sigma_load),
    .o_noise_out    (noise_out),
    .o_noise_valid  (noise_valid),
    .i_noise_ready  (noise_ready),
    .o_fill_level   (fill_level),
    .o_drop_count   (drop_count),
    .o_stat_sum     (stat_sum),
    .o_stat_count   (stat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference scaling: exact product, round half up, saturate.
  function automatic logic [31:0] ref_scale(input logic [31:0] s, input logic [31:0] g);
    longint p;
    longint r;
    p = longint'($signed(s)) * longint'($signed(g));
    r = (p + 64'sd8388608) >>> 24;
    if (r > 64'sd2147483647) return 32'h7FFF_FFFF;
    else if (r < -64'sd2147483648) return 32'h8000_0000;
    else return r[31:0];
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_s1v   = 1'b0;
    m_s1d   = 32'h0;
    m_drop  = 16'h0;
    m_sigma = 32'h0100_0000;
  endtask

  // One clock: drive inputs, advance the model, take the edge, compare.
  task automatic step(input logic en, input logic v, input logic [31:0] s,
                      input logic rdy, input logic ld, input logic [31:0] sg);
    logic pop;
    logic full;
    enable = en; sample_valid = v; sample_in = s;
    noise_ready = rdy; sigma_load = ld; sigma_in = sg;
    pop  = (m_q.size() > 0) && rdy;
    full = (m_q.size() == 16);
    if (pop) void'(m_q.pop_front());
    if (m_s1v) begin
      if (!full || pop) m_q.push_back(m_s1d);
      else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'h1;
    end
    m_s1v = en & v;
    if (en & v) m_s1d = ref_scale(s, m_sigma);
    if (ld) m_sigma = sg;
    @(posedge clk);
    #1;
    chk("valid", {63'h0, noise_valid}, {63'h0, (m_q.size() > 0)});
    chk("head", {32'h0, noise_out}, (m_q.size() > 0) ? {32'h0, m_q[0]} : 64'h0);
    chk("fill", {59'h0, fill_level}, 64'(m_q.size()));
    chk("drops", {48'h0, drop_count}, {48'h0, m_drop});
  endtask

  task automatic idle(input logic rdy);
    step(1'b1, 1'b0, 32'h0, rdy, 1'b0, 32'h0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    vecs[0] = '{"unity_half",   32'h0100_0000, 32'h0080_0000, 32'h0080_0000};
    vecs[1] = '{"quarter_neg",  32'h0040_0000, 32'hFF00_0000, 32'hFFC0_0000};
    vecs[2] = '{"sat_pos",      32'h7FFF_FFFF, 32'h7F00_0000, 32'h7FFF_FFFF};
    vecs[3] = '{"sat_neg",      32'h7FFF_FFFF, 32'h8100_0000, 32'h8000_0000};
    vecs[4] = '{"round_up_pos", 32'h0080_0000, 32'h0000_0001, 32'h0000_0001};
    vecs[5] = '{"round_up_neg", 32'h0080_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[6] = '{"round_m1_5",   32'h0080_0000, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    vecs[7] = '{"sigma_zero",   32'h0000_0000, 32'h1234_5678, 32'h0000_0000};

    rst = 1'b1; enable = 1'b0; sample_in = 32'h0; sample_valid = 1'b0;
    sigma_in = 32'h0; sigma_load = 1'b0; noise_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_valid", {63'h0, noise_valid}, 64'h0);
    chk("rst_out", {32'h0, noise_out}, 64'h0);
    chk("rst_fill", {59'h0, fill_level}, 64'h0);
    chk("rst_drop", {48'h0, drop_count}, 64'h0);
    chk("rst_ssum", {16'h0, stat_sum}, 64'h0);
    chk("rst_scnt", {32'h0, stat_count}, 64'h0);

    // Scaling table: load sigma, accept, drain, check head, pop.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, vecs[i].sigma);
      step(1'b1, 1'b1, vecs[i].sample, 1'b1, 1'b0, 32'h0);
      chk({vecs[i].name, "_lat"}, {63'h0, noise_valid}, 64'h0);
      idle(1'b0);
      chk(vecs[i].name, {32'h0, noise_out}, {32'h0, vecs[i].expv});
      chk({vecs[i].name, "_v"}, {63'h0, noise_valid}, 64'h1);
      idle(1'b1);
    end

    // Overflow: 20 samples into a stalled FIFO.
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0100_0000);
    for (int i = 1; i <= 20; i++) step(1'b1, 1'b1, 32'(i), 1'b0, 1'b0, 32'h0);
    idle(1'b0);
    chk("ovf_fill", {59'h0, fill_level}, 64'd16);
    chk("ovf_drop", {48'h0, drop_count}, 64'd4);
    for (int i = 1; i <= 16; i++) begin
      chk("pop_order", {32'h0, noise_out}, 64'(i));
      idle(1'b1);
    end
    chk("drained", {63'h0, noise_valid}, 64'h0);

    // Enable low blocks intake.
    step(1'b0, 1'b1, 32'h0300_0000, 1'b0, 1'b0, 32'h0);
    idle(1'b0);
    chk("en_low", {59'h0, fill_level}, 64'h0);

    // Full FIFO with simultaneous pop and push.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 32'(i + 40), 1'b0, 1'b0, 32'h0);
    idle(1'b0);
    step(1'b1, 1'b1, 32'd100, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'd101, 1'b1, 1'b0, 32'h0);
    chk("full_pp_fill", {59'h0, fill_level}, 64'd16);
    chk("full_pp_drop", {48'h0, drop_count}, 64'd4);
    idle(1'b1);
    chk("full_pp_fill2", {59'h0, fill_level}, 64'd16);
    step(1'b1, 1'b1, 32'd102, 1'b0, 1'b0, 32'h0);

    // Asynchronous reset mid-cycle.
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {63'h0, noise_valid}, 64'h0);
    chk("arst_fill", {59'h0, fill_level}, 64'h0);
    chk("arst_out", {32'h0, noise_out}, 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    idle(1'b0);

    // Statistics over four unit samples.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'h0100_0000, 1'b0, 1'b0, 32'h0);
    idle(1'b0);
`ifdef NOISE_STATS_EN
    chk("stat_count", {32'h0, stat_count}, 64'd4);
    chk("stat_sum", {16'h0, stat_sum}, 64'h0000_0400_0000);
`else
    chk("stat_count", {32'h0, stat_count}, 64'd0);
    chk("stat_sum", {16'h0, stat_sum}, 64'd0);
`endif
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] sg;
      logic [31:0] smp;
      sg  = $urandom() & ((($urandom_range(0, 1)) != 0) ? 32'h7FFF_FFFF : 32'h01FF_FFFF);
      smp = $urandom();
      step(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0), smp,
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0), sg);
    end
    for (int i = 0; i < 20; i++) idle(1'b1);
    chk("final_empty", {63'h0, noise_valid}, 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
